// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/control FSM driving the datapath ALU and register file.
// Optional MEM timeout with mem_err output: define ALU_ISSUE_MEM_TIMEOUT_EN.
module alu_issue #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    inst,
  input  logic          inst_valid,
  output logic          inst_ready,
  output logic [1:0]    rf_ra_a,
  output logic [1:0]    rf_ra_b,
  input  logic [DW-1:0] rf_rd_a,
  input  logic [DW-1:0] rf_rd_b,
  output logic          rf_we,
  output logic [1:0]    rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [2:0]    alu_cmd,
  output logic [1:0]    alu_typeselect,
  output logic [3:0]    alu_immed,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_sc_i,
  input  logic [DW-1:0] alu_rslt,
  input  logic          alu_sc_o,
  input  logic          alu_pari,
  input  logic          alu_zero,
  output logic          mem_req,
  output logic [5:0]    mem_sel,
  input  logic          mem_done,
  output logic          carry_flag,
  output logic          zero_flag,
  output logic          parity_flag,
`ifdef ALU_ISSUE_MEM_TIMEOUT_EN
  output logic          mem_err,
`endif
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_MEM
  } state_t;

  state_t     state, state_n;
  logic [8:0] inst_q;
  logic       mem_timeout;
`ifdef ALU_ISSUE_MEM_TIMEOUT_EN
  logic [3:0] tmo_cnt;
`endif

  assign inst_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign alu_sc_i   = carry_flag;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    mem_timeout = 1'b0;
    case (state)
      S_IDLE: if (inst_valid) state_n = S_READ;
      S_READ: state_n = (inst_q[8:6] == 3'b010) ? S_MEM : S_EXEC;
      S_EXEC: state_n = S_WB;
      S_WB:   state_n = S_IDLE;
      S_MEM: begin
        if (mem_done) begin
          state_n = S_IDLE;
`ifdef ALU_ISSUE_MEM_TIMEOUT_EN
        end else if (tmo_cnt == 4'hF) begin
          state_n     = S_IDLE;
          mem_timeout = 1'b1;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Every control output is loaded on entry to its owning state and cleared otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inst_q         <= '0;
      rf_ra_a        <= '0;
      rf_ra_b        <= '0;
      rf_we          <= 1'b0;
      rf_wa          <= '0;
      rf_wd          <= '0;
      alu_cmd        <= '0;
      alu_typeselect <= '0;
      alu_immed      <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      mem_req        <= 1'b0;
      mem_sel        <= '0;
      carry_flag     <= 1'b0;
      zero_flag      <= 1'b0;
      parity_flag    <= 1'b0;
    end else begin
      if (state == S_IDLE && inst_valid) inst_q <= inst;

      rf_ra_a <= (state_n == S_READ) ? inst[5:4] : 2'b00;
      rf_ra_b <= (state_n == S_READ) ? inst[3:2] : 2'b00;

      alu_cmd        <= (state_n == S_EXEC) ? inst_q[8:6] : 3'b000;
      alu_typeselect <= (state_n == S_EXEC) ? inst_q[1:0] : 2'b00;
      alu_immed      <= (state_n == S_EXEC) ? inst_q[3:0] : 4'h0;
      alu_a          <= (state_n == S_EXEC) ? rf_rd_a : '0;
      alu_b          <= (state_n == S_EXEC) ? rf_rd_b : '0;

      rf_we <= (state_n == S_WB);
      rf_wa <= (state_n == S_WB) ? inst_q[5:4] : 2'b00;
      rf_wd <= (state == S_EXEC) ? alu_rslt : '0;

      mem_req <= (state_n == S_MEM);
      mem_sel <= (state_n == S_MEM) ? inst_q[5:0] : 6'h00;

      if (state == S_EXEC) begin
        zero_flag   <= alu_zero;
        parity_flag <= alu_pari;
        // Only subtract and shift produce an architectural carry.
        if (inst_q[8:6] == 3'b001 || inst_q[8:6] == 3'b110) carry_flag <= alu_sc_o;
      end
    end
  end

`ifdef ALU_ISSUE_MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_MEM) ? tmo_cnt + 4'd1 : 4'd0;
      mem_err <= mem_timeout;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed bench for alu_issue with a small register file and ALU model.
module tb_alu_issue;
  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] inst;
  logic       inst_valid;
  logic       inst_ready;
  logic [1:0] rf_ra_a, rf_ra_b, rf_wa;
  logic [7:0] rf_rd_a, rf_rd_b, rf_wd;
  logic       rf_we;
  logic [2:0] alu_cmd;
  logic [1:0] alu_typeselect;
  logic [3:0] alu_immed;
  logic [7:0] alu_a, alu_b, alu_rslt;
  logic       alu_sc_i, alu_sc_o, alu_pari, alu_zero;
  logic       mem_req;
  logic [5:0] mem_sel;
  logic       mem_done;
  logic       carry_flag, zero_flag, parity_flag, busy;
`ifdef ALU_ISSUE_MEM_TIMEOUT_EN
  logic       mem_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] rf [4];
  logic       tb_we;
  logic [1:0] tb_wa;
  logic [7:0] tb_wd;

  always #5 clk = ~clk;

  alu_issue #(.DW(8)) dut (
    .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .rf_ra_a(rf_ra_a), .rf_ra_b(rf_ra_b), .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_cmd(alu_cmd), .alu_typeselect(alu_typeselect), .alu_immed(alu_immed),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt),
    .alu_sc_o(alu_sc_o), .alu_pari(alu_pari), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_done(mem_done),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .parity_flag(parity_flag),
`ifdef ALU_ISSUE_MEM_TIMEOUT_EN
    .mem_err(mem_err),
`endif
    .busy(busy)
  );

  // Register file: combinational read, DUT write has priority over bench preload.
  always @(posedge clk) begin
    if (rf_we) rf[rf_wa] <= rf_wd;
    else if (tb_we) rf[tb_wa] <= tb_wd;
  end
  assign rf_rd_a = rf[rf_ra_a];
  assign rf_rd_b = rf[rf_ra_b];

  // ALU model: 110 subtract with borrow out, 001 left shift through carry, 100 OR immediate, else add.
  logic [8:0] alu_full;
  always_comb begin
    alu_full = '0;
    case (alu_cmd)
      3'b110:  alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      3'b001:  alu_full = {alu_a[7], alu_a[6:0], alu_sc_i};
      3'b100:  alu_full = {1'b0, alu_a | {4'h0, alu_immed}};
      default: alu_full = {1'b0, alu_a + alu_b};
    endcase
  end
  assign alu_rslt = alu_full[7:0];
  assign alu_sc_o = alu_full[8];
  assign alu_zero = (alu_full[7:0] == 8'h00);
  assign alu_pari = ^alu_full[7:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic start(input logic [8:0] w);
    @(negedge clk);
    inst = w; inst_valid = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [8:0] w, input logic [7:0] ea, input logic [7:0] eb,
                         input logic esc, input logic [7:0] ewd, input logic ec, input logic ez);
    start(w);
    @(negedge clk);
    check({tag, ".ra_a"}, rf_ra_a, w[5:4]);
    check({tag, ".ra_b"}, rf_ra_b, w[3:2]);
    check({tag, ".read_ready"}, inst_ready, 0);
    @(negedge clk);
    check({tag, ".cmd"}, alu_cmd, w[8:6]);
    check({tag, ".alu_a"}, alu_a, ea);
    check({tag, ".alu_b"}, alu_b, eb);
    check({tag, ".sc_i"}, alu_sc_i, esc);
    check({tag, ".type"}, alu_typeselect, w[1:0]);
    check({tag, ".immed"}, alu_immed, w[3:0]);
    check({tag, ".exec_we"}, rf_we, 0);
    @(negedge clk);
    check({tag, ".we"}, rf_we, 1);
    check({tag, ".wa"}, rf_wa, w[5:4]);
    check({tag, ".wd"}, rf_wd, ewd);
    check({tag, ".carry"}, carry_flag, ec);
    check({tag, ".zero"}, zero_flag, ez);
    @(negedge clk);
    check({tag, ".we_off"}, rf_we, 0);
    check({tag, ".ready"}, inst_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; inst = '0; inst_valid = 1'b0; mem_done = 1'b0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("rst.ready", inst_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.flags", {carry_flag, zero_flag, parity_flag}, 3'b000);
    check("rst.we", rf_we, 0);
    check("rst.mem_req", mem_req, 0);
    check("rst.alu_a", alu_a, 0);

    // 5 - 3 = 2, no borrow, parity of 0x02 is 1
    set_reg(2'd1, 8'h05);
    set_reg(2'd2, 8'h03);
    run_alu("sub1", 9'b110_01_10_00, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    check("sub1.parity", parity_flag, 1);
    check("sub1.rf1", rf[1], 8'h02);

    // 3 - 5 = 0xFE with borrow
    set_reg(2'd1, 8'h03);
    set_reg(2'd2, 8'h05);
    run_alu("sub2", 9'b110_01_10_00, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);

    // shift r1=0xFE left through carry=1: 0xFD, carry out 1
    set_reg(2'd0, 8'h00);
    run_alu("shl", 9'b001_01_00_11, 8'hFE, 8'h00, 1'b1, 8'hFD, 1'b1, 1'b0);

    // 0x50 | 0xA = 0x5A, carry held, parity of 0x5A is 0
    set_reg(2'd2, 8'h50);
    run_alu("imm", 9'b100_10_1010, 8'h50, 8'h50, 1'b1, 8'h5A, 1'b1, 1'b0);
    check("imm.rf2", rf[2], 8'h5A);
    check("imm.parity", parity_flag, 0);

    // memory op with inst_valid held; a second (add) op waits behind it
    @(negedge clk);
    inst = 9'b010_11_0110; inst_valid = 1'b1;
    @(posedge clk);
    #1 inst = 9'b000_00_01_00;
    @(negedge clk);
    check("mem.read_ready", inst_ready, 0);
    check("mem.read_req", mem_req, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mem.req", mem_req, 1);
      check("mem.sel", mem_sel, 6'b110110);
      check("mem.ready", inst_ready, 0);
      check("mem.we", rf_we, 0);
      if (i == 4) mem_done = 1'b1;
    end
    @(posedge clk);
    #1 mem_done = 1'b0;
    @(negedge clk);
    check("mem.req_drop", mem_req, 0);
    check("mem.idle_ready", inst_ready, 1);
    check("mem.flags", {carry_flag, zero_flag, parity_flag}, 3'b100);
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
    check("add.busy", busy, 1);
    check("add.ra_b", rf_ra_b, 2'd1);
    check("add.req", mem_req, 0);
    @(negedge clk);
    check("add.alu_a", alu_a, 8'h00);
    check("add.alu_b", alu_b, 8'hFD);
    @(negedge clk);
    check("add.we", rf_we, 1);
    check("add.wa", rf_wa, 2'd0);
    check("add.wd", rf_wd, 8'hFD);
    check("add.carry", carry_flag, 1);
    @(negedge clk);
    check("add.ready", inst_ready, 1);

    // reset in the middle of EXEC aborts write-back
    start(9'b110_01_10_00);
    @(negedge clk);
    @(negedge clk);
    check("abort.exec", alu_cmd, 3'b110);
    reset = 1'b0;
    @(negedge clk);
    check("abort.we", rf_we, 0);
    check("abort.flags", {carry_flag, zero_flag, parity_flag}, 3'b000);
    check("abort.ready", inst_ready, 1);
    check("abort.busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort.we2", rf_we, 0);

`ifdef ALU_ISSUE_MEM_TIMEOUT_EN
    begin
      int req_cycles;
      int err_pulses;
      req_cycles = 0;
      err_pulses = 0;
      start(9'b010_00_0000);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (mem_req) req_cycles++;
        if (mem_err) err_pulses++;
      end
      check("tmo.req_cycles", req_cycles, 16);
      check("tmo.err_pulses", err_pulses, 1);
      check("tmo.ready", inst_ready, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
